// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/ack data bus with a watchdog and registers the MEM/WB fields.
// Build option: define MEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of issuing them.
module mem_stage_lsu #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mem_fault
);

   typedef enum logic {IDLE, BUS} state_t;

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [4:0]  rd_q;
   logic        rw_q, load_q;

   logic        mem_op, f3_bad, misalign, fault_now, accept, expire;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt, load_data;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      mem_op = ex_valid & (ex_mem_read | ex_mem_write);
      f3_bad = (ex_funct3 == 3'b011) | (ex_funct3 == 3'b110) | (ex_funct3 == 3'b111);
`ifdef MEM_MISALIGN_TRAP_EN
      misalign = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                 ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      fault_now = mem_op & (f3_bad | misalign);
      accept    = (state == IDLE) & mem_op & ~fault_now;
      expire    = (state == BUS) & ~dmem_ack & (wait_cnt == 8'(MAX_WAIT - 1));
   end

   // Byte enables and lane replication follow the access size for loads and stores alike.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = ex_store_data;
      case (ex_funct3[1:0])
         2'b00: begin
            be_nxt    = 4'b0001 << ex_addr[1:0];
            wdata_nxt = {4{ex_store_data[7:0]}};
         end
         2'b01: begin
            be_nxt    = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{ex_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lane_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
      lane_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
         3'b100:  load_data = {24'b0, lane_byte};
         3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
         3'b101:  load_data = {16'b0, lane_half};
         default: load_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Faulting accesses never enter BUS, so they do not hold the pipeline.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            stall = accept;
            if (accept) state_nxt = BUS;
         end
         BUS: begin
            stall = ~dmem_ack & ~expire;
            if (dmem_ack | expire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!reset) stall = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_be      <= '0;
         dmem_wdata   <= '0;
         wait_cnt     <= '0;
         f3_q         <= '0;
         lane_q       <= '0;
         rd_q         <= '0;
         rw_q         <= 1'b0;
         load_q       <= 1'b0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         mem_fault    <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         mem_fault    <= 1'b0;
         case (state)
            IDLE: begin
               if (fault_now) begin
                  wb_valid  <= 1'b1;
                  mem_fault <= 1'b1;
                  wb_rd     <= ex_rd;
                  wb_data   <= '0;
               end else if (mem_op) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= ex_mem_write;
                  dmem_addr  <= {ex_addr[31:2], 2'b00};
                  dmem_be    <= be_nxt;
                  dmem_wdata <= wdata_nxt;
                  wait_cnt   <= '0;
                  f3_q       <= ex_funct3;
                  lane_q     <= ex_addr[1:0];
                  rd_q       <= ex_rd;
                  rw_q       <= ex_reg_write;
                  load_q     <= ~ex_mem_write;
               end else if (ex_valid) begin
                  wb_valid     <= 1'b1;
                  wb_data      <= ex_addr;
                  wb_rd        <= ex_rd;
                  wb_reg_write <= ex_reg_write;
               end
            end
            BUS: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_rd    <= rd_q;
                  if (load_q) begin
                     wb_data      <= load_data;
                     wb_reg_write <= rw_q;
                  end else begin
                     wb_data <= '0;
                  end
               end else if (expire) begin
                  dmem_req  <= 1'b0;
                  wb_valid  <= 1'b1;
                  mem_fault <= 1'b1;
                  wb_rd     <= rd_q;
                  wb_data   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (MAX_WAIT = 15).
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_store_data;
   logic [4:0]  ex_rd;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid, wb_reg_write, mem_fault;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;
   int stall_cnt;

   mem_stage_lsu #(.MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
      ex_funct3 = 3'b000; ex_addr = '0; ex_store_data = '0; ex_rd = '0;
   endtask

   // Presents a mem op, counts its accept-cycle stall, and advances into the first bus cycle.
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd);
      ex_valid = 1; ex_mem_read = ~wr; ex_mem_write = wr; ex_reg_write = 1;
      ex_funct3 = f3; ex_addr = addr; ex_store_data = sdata; ex_rd = rd;
      #1;
      stall_cnt = stall ? 1 : 0;
      step();
   endtask

   task automatic finish_access(input int unsigned waits, input logic [31:0] rdata);
      for (int unsigned i = 0; i < waits; i++) begin
         if (stall) stall_cnt++;
         step();
      end
      dmem_ack = 1; dmem_rdata = rdata;
      #1;
      if (stall) stall_cnt++;
      step();
      dmem_ack = 0; dmem_rdata = '0;
      clear_ex();
   endtask

   task automatic test_reset();
      reset = 0; dmem_ack = 0; dmem_rdata = '0;
      clear_ex();
      step();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
      checks++; if ({wb_valid, wb_reg_write, mem_fault, wb_rd, wb_data} !== '0) begin
         errors++; $display("FAIL reset_wb: got %b %b %b %h %h expected all 0", wb_valid, wb_reg_write, mem_fault, wb_rd, wb_data);
      end
      reset = 1;
      step();
   endtask

   task automatic test_passthrough();
      ex_valid = 1; ex_reg_write = 1; ex_addr = 32'h1234; ex_rd = 5'd5;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b expected 0", stall); end
      step();
      clear_ex();
      checks++; if ({wb_valid, wb_reg_write} !== 2'b11) begin errors++; $display("FAIL pass_valid: got %b expected 11", {wb_valid, wb_reg_write}); end
      checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL pass_data: got %h expected 00001234", wb_data); end
      checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL pass_rd: got %0d expected 5", wb_rd); end
      step();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b expected 0", wb_valid); end
   endtask

   task automatic test_stores();
      issue(1'b1, 3'b000, 32'h103, 32'h000000AB, 5'd3);
      checks++; if ({dmem_req, dmem_we} !== 2'b11) begin errors++; $display("FAIL sb_req: got %b expected 11", {dmem_req, dmem_we}); end
      checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", dmem_be); end
      checks++; if (dmem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h expected ababab ab", dmem_wdata); end
      checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h expected 00000100", dmem_addr); end
      finish_access(3, 32'h0);
      checks++; if (stall_cnt != 4) begin errors++; $display("FAIL sb_stall_cycles: got %0d expected 4", stall_cnt); end
      checks++; if ({wb_valid, wb_reg_write, dmem_req} !== 3'b100) begin
         errors++; $display("FAIL sb_wb: got valid/rw/req %b expected 100", {wb_valid, wb_reg_write, dmem_req});
      end
      issue(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd4);
      checks++; if ({dmem_be, dmem_wdata} !== {4'b1100, 32'hABCDABCD}) begin
         errors++; $display("FAIL sh_lane: got %b %h expected 1100 abcdabcd", dmem_be, dmem_wdata);
      end
      finish_access(0, 32'h0);
      issue(1'b1, 3'b010, 32'h10C, 32'hDEADBEEF, 5'd4);
      checks++; if ({dmem_be, dmem_wdata, dmem_addr} !== {4'b1111, 32'hDEADBEEF, 32'h10C}) begin
         errors++; $display("FAIL sw_bus: got %b %h %h expected 1111 deadbeef 0000010c", dmem_be, dmem_wdata, dmem_addr);
      end
      finish_access(1, 32'h0);
   endtask

   task automatic test_loads();
      issue(1'b0, 3'b000, 32'h102, 32'h0, 5'd7);
      checks++; if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h100}) begin
         errors++; $display("FAIL lb_bus: got %b %b %h expected 1 0 00000100", dmem_req, dmem_we, dmem_addr);
      end
      finish_access(0, 32'h00800000);
      checks++; if (stall_cnt != 1) begin errors++; $display("FAIL lb_stall_cycles: got %0d expected 1", stall_cnt); end
      checks++; if (wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h expected ffffff80", wb_data); end
      checks++; if ({wb_valid, wb_reg_write, wb_rd} !== {2'b11, 5'd7}) begin
         errors++; $display("FAIL lb_wb: got %b %b %0d expected 1 1 7", wb_valid, wb_reg_write, wb_rd);
      end
      issue(1'b0, 3'b100, 32'h102, 32'h0, 5'd7);
      finish_access(0, 32'h00800000);
      checks++; if (wb_data !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h expected 00000080", wb_data); end
      issue(1'b0, 3'b000, 32'h101, 32'h0, 5'd8);
      finish_access(2, 32'h00007F00);
      checks++; if (wb_data !== 32'h0000007F) begin errors++; $display("FAIL lb_pos: got %h expected 0000007f", wb_data); end
      issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd8);
      finish_access(0, 32'h80010000);
      checks++; if (wb_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext: got %h expected ffff8001", wb_data); end
      issue(1'b0, 3'b101, 32'h100, 32'h0, 5'd8);
      finish_access(0, 32'h1234F00F);
      checks++; if (wb_data !== 32'h0000F00F) begin errors++; $display("FAIL lhu_zext: got %h expected 0000f00f", wb_data); end
      issue(1'b0, 3'b010, 32'h104, 32'h0, 5'd8);
      finish_access(0, 32'hDEADBEEF);
      checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_word: got %h expected deadbeef", wb_data); end
   endtask

   task automatic test_watchdog();
      int req_cnt = 0, fault_cnt = 0, fault_at = -1, drop_at = -1, late_wb = 0;
      logic fault_wbv = 0, fault_rw = 1;
      issue(1'b0, 3'b010, 32'h200, 32'h0, 5'd9);
      for (int c = 0; c < 24; c++) begin
         if (dmem_req) req_cnt++;
         if (mem_fault) begin fault_cnt++; fault_at = c; fault_wbv = wb_valid; fault_rw = wb_reg_write; end
         if (c >= 16 && wb_valid) late_wb++;
         if (!stall && drop_at < 0) begin drop_at = c; clear_ex(); end
         dmem_ack = (c == 16);
         step();
      end
      dmem_ack = 0;
      checks++; if (req_cnt != 15) begin errors++; $display("FAIL wd_req_cycles: got %0d expected 15", req_cnt); end
      checks++; if (fault_cnt != 1 || fault_at != 15) begin errors++; $display("FAIL wd_fault_pulse: got %0d at %0d expected 1 at 15", fault_cnt, fault_at); end
      checks++; if (drop_at != 14) begin errors++; $display("FAIL wd_stall_drop: got %0d expected 14", drop_at); end
      checks++; if ({fault_wbv, fault_rw} !== 2'b10) begin errors++; $display("FAIL wd_fault_wb: got %b expected 10", {fault_wbv, fault_rw}); end
      checks++; if (late_wb != 0) begin errors++; $display("FAIL wd_late_ack: got %0d wb cycles expected 0", late_wb); end
   endtask

   task automatic test_ack_at_limit();
      issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd9);
      finish_access(14, 32'h55AA00FF);
      checks++; if (stall_cnt != 15) begin errors++; $display("FAIL limit_stall_cycles: got %0d expected 15", stall_cnt); end
      checks++; if ({wb_valid, wb_reg_write, mem_fault, wb_data} !== {3'b110, 32'h55AA00FF}) begin
         errors++; $display("FAIL limit_ack_wins: got %b%b%b %h expected 110 55aa00ff", wb_valid, wb_reg_write, mem_fault, wb_data);
      end
   endtask

   task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_funct3 = 3'b010; ex_addr = 32'h102; ex_rd = 5'd10;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", stall); end
      step();
      clear_ex();
      checks++; if ({dmem_req, mem_fault, wb_valid, wb_reg_write} !== 4'b0110) begin
         errors++; $display("FAIL mis_trap: got req/fault/valid/rw %b expected 0110", {dmem_req, mem_fault, wb_valid, wb_reg_write});
      end
      step();
`else
      issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd10);
      checks++; if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h100, 4'b1111}) begin
         errors++; $display("FAIL mis_bus: got %b %h %b expected 1 00000100 1111", dmem_req, dmem_addr, dmem_be);
      end
      finish_access(0, 32'hCAFEF00D);
      checks++; if ({wb_valid, mem_fault, wb_data} !== {2'b10, 32'hCAFEF00D}) begin
         errors++; $display("FAIL mis_load: got %b %b %h expected 1 0 cafef00d", wb_valid, mem_fault, wb_data);
      end
`endif
   endtask

   task automatic test_bad_funct3();
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_funct3 = 3'b011; ex_addr = 32'h500; ex_rd = 5'd11;
      step();
      clear_ex();
      checks++; if ({dmem_req, mem_fault, wb_valid, wb_reg_write} !== 4'b0110) begin
         errors++; $display("FAIL bad_f3: got req/fault/valid/rw %b expected 0110", {dmem_req, mem_fault, wb_valid, wb_reg_write});
      end
      step();
      checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL bad_f3_pulse: got %b expected 0", mem_fault); end
   endtask

   task automatic test_reset_mid_bus();
      issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd12);
      step();
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b expected 1", dmem_req); end
      reset = 0;
      #1;
      checks++; if ({stall, dmem_req, wb_valid, mem_fault} !== 4'b0000) begin
         errors++; $display("FAIL rst_async: got stall/req/valid/fault %b expected 0000", {stall, dmem_req, wb_valid, mem_fault});
      end
      clear_ex();
      step();
      reset = 1;
      step();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_no_wb: got %b expected 0", wb_valid); end
      issue(1'b0, 3'b010, 32'h304, 32'h0, 5'd13);
      finish_access(1, 32'h11223344);
      checks++; if ({wb_valid, wb_reg_write, wb_rd, wb_data} !== {2'b11, 5'd13, 32'h11223344}) begin
         errors++; $display("FAIL rst_recover: got %b %b %0d %h expected 1 1 13 11223344", wb_valid, wb_reg_write, wb_rd, wb_data);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_stores();
      test_loads();
      test_watchdog();
      test_ack_at_limit();
      test_misalign();
      test_bad_funct3();
      test_reset_mid_bus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
